// File: rtl/channelizer_accum_if.sv
// Sample/result stream bundle for channelizer_accum.
//   slave  : the accumulator side (consumes FFT samples, produces bin words)
//   master : the environment side (drives FFT samples, accepts bin words)
// Signals:
//   fft_ready, in_valid, in_data          FFT sample stream (no back-pressure)
//   out_valid, out_ready, out_data,
//   out_bin, out_last                     averaged-bin output stream
interface channelizer_accum_if #(
  parameter int N     = 16,
  parameter int N_out = 8,
  parameter int BINS  = 4
);
  localparam int BW = $clog2(BINS);

  logic             fft_ready;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_out-1:0] out_data;
  logic [BW-1:0]    out_bin;
  logic             out_last;

  modport slave (
    input  fft_ready, in_valid, in_data, out_ready,
    output out_valid, out_data, out_bin, out_last
  );

  modport master (
    output fft_ready, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_bin, out_last
  );
endinterface

// File: rtl/channelizer_accum.sv
// channelizer_accum: averages N_AVGS spectrum frames per bin and streams the
// shifted/width-selected bins out with valid/ready.
// Ports:
//   clk, arest_n   clock, async active-low reset
//   bus            channelizer_accum_if.slave (sample input + bin output stream)
//   N_AVGS_in      frames per epoch (0 acts as 1), latched at epoch start
//   shift_in       arithmetic right shift before width selection, latched at epoch start
//   err_frame      1-cycle pulse the cycle after a mid-frame fft_ready
//   err_ovf        1-cycle pulse the cycle after an epoch ended into a busy buffer
// Build option: CHANNELIZER_SAT_EN -> saturate accumulator and output selection
// instead of wrapping.
module channelizer_accum #(
  parameter int N         = 16,
  parameter int N_out     = 8,
  parameter int SUM_WIDTH = 32,
  parameter int BINS      = 4,
  parameter int SHW       = 5
) (
  input  logic               clk,
  input  logic               arest_n,
  channelizer_accum_if.slave bus,
  input  logic [7:0]         N_AVGS_in,
  input  logic [SHW-1:0]     shift_in,
  output logic               err_frame,
  output logic               err_ovf
);
  localparam int BW = $clog2(BINS);

  typedef logic [SUM_WIDTH-1:0] sum_t;
  typedef logic [N_out-1:0]     word_t;
  typedef enum logic {IDLE, ACCUM} state_t;

`ifdef CHANNELIZER_SAT_EN
  localparam logic signed [SUM_WIDTH-1:0] OUT_MAX = {{(SUM_WIDTH-N_out+1){1'b0}}, {(N_out-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [SUM_WIDTH-1:0]        ACC_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0]        ACC_MIN = ~ACC_MAX;
`endif

  function automatic sum_t acc_add(input sum_t a, input sum_t b);
`ifdef CHANNELIZER_SAT_EN
    logic [SUM_WIDTH:0] s;
    s = {a[SUM_WIDTH-1], a} + {b[SUM_WIDTH-1], b};
    // sign of the extended sum disagrees with the top kept bit -> overflow
    if (s[SUM_WIDTH] != s[SUM_WIDTH-1]) acc_add = s[SUM_WIDTH] ? ACC_MIN : ACC_MAX;
    else                                acc_add = s[SUM_WIDTH-1:0];
`else
    acc_add = a + b;
`endif
  endfunction

  function automatic word_t sel(input sum_t x, input logic [SHW-1:0] sh);
`ifdef CHANNELIZER_SAT_EN
    logic signed [SUM_WIDTH-1:0] v;
    v = $signed(x) >>> sh;
    if (v > OUT_MAX)      sel = OUT_MAX[N_out-1:0];
    else if (v < OUT_MIN) sel = OUT_MIN[N_out-1:0];
    else                  sel = v[N_out-1:0];
`else
    sel = N_out'($signed(x) >>> sh);
`endif
  endfunction

  state_t                         state, state_nx;
  logic [BW-1:0]                  bin_cnt, bin_nx, cur_bin, out_idx;
  logic [7:0]                     frame_cnt, navg_l;
  logic [SHW-1:0]                 shift_l;
  logic [BINS-1:0][SUM_WIDTH-1:0] acc, acc_nx;
  logic [BINS-1:0][N_out-1:0]     out_buf, buf_nx;
  logic                           start, take, last_bin, epoch_end, mid_err;
  logic                           busy, fire, load, out_valid_q;
  sum_t                           sext_in, new_val;

  // In ACCUM, bin_cnt is the next expected bin and is never 0, so any
  // fft_ready seen in ACCUM is a mid-frame restart.
  assign start     = bus.in_valid & bus.fft_ready;
  assign take      = bus.in_valid & (bus.fft_ready | (state == ACCUM));
  assign cur_bin   = start ? '0 : bin_cnt;
  assign last_bin  = (cur_bin == BW'(BINS-1));
  assign epoch_end = take & last_bin & (frame_cnt == navg_l - 8'd1);
  assign sext_in   = {{(SUM_WIDTH-N){bus.in_data[N-1]}}, bus.in_data};
  assign new_val   = (frame_cnt == 8'd0) ? sext_in : acc_add(acc[cur_bin], sext_in);

  // Buffer stays busy unless its final word leaves this very cycle.
  assign fire = out_valid_q & bus.out_ready;
  assign busy = out_valid_q & ~(bus.out_ready & bus.out_last);
  assign load = epoch_end & ~busy;

  always_comb begin
    state_nx = state;
    bin_nx   = bin_cnt;
    mid_err  = 1'b0;
    if (take) begin
      mid_err = start & (state == ACCUM);
      if (last_bin) begin
        state_nx = IDLE;
        bin_nx   = '0;
      end else begin
        state_nx = ACCUM;
        bin_nx   = cur_bin + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      state   <= IDLE;
      bin_cnt <= '0;
    end else begin
      state   <= state_nx;
      bin_cnt <= bin_nx;
    end
  end

  // Per-bin accumulate and buffer load; the last bin's result bypasses the
  // accumulator so the stream can start one clock after the final sample.
  for (genvar g = 0; g < BINS; g++) begin : g_bin
    assign acc_nx[g] = (take && (cur_bin == BW'(g))) ? new_val : acc[g];
    assign buf_nx[g] = load ? sel((g == BINS-1) ? new_val : acc[g], shift_l) : out_buf[g];
  end

  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      frame_cnt   <= '0;
      navg_l      <= 8'd1;
      shift_l     <= '0;
      acc         <= '0;
      out_buf     <= '0;
      out_valid_q <= 1'b0;
      out_idx     <= '0;
      err_frame   <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      acc       <= acc_nx;
      out_buf   <= buf_nx;
      err_frame <= mid_err;
      err_ovf   <= epoch_end & busy;
      if (start && frame_cnt == 8'd0) begin
        navg_l  <= (N_AVGS_in == 8'd0) ? 8'd1 : N_AVGS_in;
        shift_l <= shift_in;
      end
      if (take && last_bin) frame_cnt <= epoch_end ? 8'd0 : frame_cnt + 8'd1;
      if (load) begin
        out_valid_q <= 1'b1;
        out_idx     <= '0;
      end else if (fire) begin
        if (bus.out_last) begin
          out_valid_q <= 1'b0;
          out_idx     <= '0;
        end else begin
          out_idx <= out_idx + BW'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_buf[out_idx];
  assign bus.out_bin   = out_idx;
  assign bus.out_last  = out_valid_q & (out_idx == BW'(BINS-1));
endmodule

// File: tb/tb_channelizer_accum.sv
// Bench for channelizer_accum (default parameters). A behavioural model tracks
// frames/epochs with plain integers and predicts every output each cycle;
// directed scenarios also pin literal results.
module tb_channelizer_accum;
  localparam int N = 16, N_OUT = 8, SUM_WIDTH = 32, BINS = 4, SHW = 5;

  logic clk = 1'b0, arest_n = 1'b1;
  logic iv = 1'b0, fr = 1'b0, ordy = 1'b0;
  logic [N-1:0] din = '0;
  logic [7:0] navg_in = 8'd1;
  logic [SHW-1:0] sh_in = '0;
  logic err_frame, err_ovf;

  channelizer_accum_if #(.N(N), .N_out(N_OUT), .BINS(BINS)) bus ();
  assign bus.in_valid  = iv;
  assign bus.fft_ready = fr;
  assign bus.in_data   = din;
  assign bus.out_ready = ordy;

  channelizer_accum #(.N(N), .N_out(N_OUT), .SUM_WIDTH(SUM_WIDTH), .BINS(BINS), .SHW(SHW)) dut (
    .clk(clk), .arest_n(arest_n), .bus(bus), .N_AVGS_in(navg_in), .shift_in(sh_in),
    .err_frame(err_frame), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [7:0] got_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int madd(input int a, input int b);
`ifdef CHANNELIZER_SAT_EN
    longint t, lmax, lmin;
    lmax = 64'sd2147483647;
    lmin = -lmax - 64'sd1;
    t = longint'(a) + longint'(b);
    if (t > lmax) t = lmax;
    if (t < lmin) t = lmin;
    return int'(t);
`else
    return a + b;
`endif
  endfunction

  function automatic logic [7:0] msel(input int v, input int sh);
    int t;
    t = v >>> sh;
`ifdef CHANNELIZER_SAT_EN
    if (t > 127) t = 127;
    else if (t < -128) t = -128;
`endif
    return 8'(t);
  endfunction

  bit m_infr, m_ov, m_ef, m_eo;
  int m_pos, m_fcnt, m_navg, m_sh, m_oidx;
  int m_sum[BINS];
  logic [7:0] m_obuf[BINS];

  always @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      m_infr = 0; m_ov = 0; m_ef = 0; m_eo = 0;
      m_pos = 0; m_fcnt = 0; m_navg = 1; m_sh = 0; m_oidx = 0;
      for (int k = 0; k < BINS; k++) begin m_sum[k] = 0; m_obuf[k] = 8'h00; end
    end else begin
      bit busy, done;
      int b;
      busy = m_ov && !(ordy && m_oidx == BINS-1);
      m_ef = 0; m_eo = 0; done = 0; b = -1;
      if (m_ov && ordy) begin
        if (m_oidx == BINS-1) begin m_ov = 0; m_oidx = 0; end
        else m_oidx++;
      end
      if (iv && fr) begin
        if (m_infr) m_ef = 1;
        if (m_fcnt == 0) begin m_navg = (navg_in == 0) ? 1 : int'(navg_in); m_sh = int'(sh_in); end
        b = 0;
      end else if (iv && m_infr) b = m_pos;
      if (b >= 0) begin
        m_sum[b] = (m_fcnt == 0) ? int'($signed(din)) : madd(m_sum[b], int'($signed(din)));
        if (b == BINS-1) begin
          m_infr = 0;
          if (m_fcnt == m_navg-1) begin done = 1; m_fcnt = 0; end
          else m_fcnt++;
        end else begin
          m_infr = 1; m_pos = b + 1;
        end
      end
      if (done) begin
        if (busy) m_eo = 1;
        else begin
          for (int k = 0; k < BINS; k++) m_obuf[k] = msel(m_sum[k], m_sh);
          m_ov = 1; m_oidx = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", bus.out_valid, m_ov);
      chk("err_frame", err_frame, m_ef);
      chk("err_ovf", err_ovf, m_eo);
      if (m_ov) begin
        chk("out_data", bus.out_data, m_obuf[m_oidx]);
        chk("out_bin", bus.out_bin, m_oidx);
        chk("out_last", bus.out_last, (m_oidx == BINS-1));
      end else begin
        chk("out_last_idle", bus.out_last, 0);
      end
      if (arest_n && bus.out_valid && ordy) got_q.push_back(bus.out_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic smp(input logic f, input int v);
    iv = 1'b1; fr = f; din = 16'(v);
    @(posedge clk); #1;
    iv = 1'b0; fr = 1'b0;
  endtask

  task automatic frame(input int v0, input int v1, input int v2, input int v3);
    smp(1'b1, v0); smp(1'b0, v1); smp(1'b0, v2); smp(1'b0, v3);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    ordy = 1'b1;
    while (bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "_drained"}, bus.out_valid, 0);
  endtask

  task automatic chk_words(input string nm, input int base, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_w%0d", nm, k), (got_q.size() > base + k) ? got_q[base + k] : 8'hxx, e[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, then single-frame epochs with shift 8
    #17 arest_n = 1'b0; chk_en = 1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_bin", bus.out_bin, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("model_sel_a", msel(32'h5af7, 8), 8'h5a);
    chk("model_sel_b", msel(int'($signed(16'h9a7b)), 8), 8'h9a);
    @(posedge clk); #1 arest_n = 1'b1;
    @(posedge clk); #1;
    navg_in = 8'd1; sh_in = 5'd8; ordy = 1'b1;
    got_q.delete();
    frame(16'h5af7, 16'h9a7b, 16'h1234, 16'hfedc);
    chk("t1_valid_lat", bus.out_valid, 1);
    chk("t1_bin0", bus.out_bin, 0);
    drain("t1");
    chk("t1_cnt", got_q.size(), 4);
    chk_words("t1", 0, 8'h5a, 8'h9a, 8'h12, 8'hfe);

    // 2: two-frame average, shift 9
    navg_in = 8'd2; sh_in = 5'd9; got_q.delete();
    frame(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
    drain("t2");
    chk_words("t2", 0, 8'h0c, 8'h0c, 8'h0c, 8'h0c);

    // 3: mid-frame restart in frame 1 keeps the partial contributions
    navg_in = 8'd2; sh_in = 5'd0; got_q.delete();
    frame(10, 20, 30, 40);
    smp(1'b1, 1); smp(1'b0, 2);
    smp(1'b1, 5);
    chk("t3_err_frame", err_frame, 1);
    smp(1'b0, 6);
    chk("t3_err_frame_off", err_frame, 0);
    smp(1'b0, 7); smp(1'b0, 8);
    drain("t3");
    chk("t3_cnt", got_q.size(), 4);
    chk_words("t3", 0, 8'h10, 8'h1c, 8'h25, 8'h30);

    // 4a: overflow while the buffer is stalled
    navg_in = 8'd1; sh_in = 5'd0; ordy = 1'b0; got_q.delete();
    frame(1, 2, 3, 4);
    frame(5, 6, 7, 8);
    chk("t4_err_ovf", err_ovf, 1);
    drain("t4a");
    chk("t4a_cnt", got_q.size(), 4);
    chk_words("t4a", 0, 8'h01, 8'h02, 8'h03, 8'h04);

    // 4b: last-word accept on the epoch-end cycle loads the new result
    ordy = 1'b0; got_q.delete();
    frame(9, 10, 11, 12);
    smp(1'b1, 13); smp(1'b0, 14); smp(1'b0, 15);
    ordy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    smp(1'b0, 16);
    chk("t4b_no_ovf", err_ovf, 0);
    chk("t4b_reload", bus.out_valid, 1);
    chk("t4b_bin0", bus.out_bin, 0);
    drain("t4b");
    chk("t4b_cnt", got_q.size(), 8);
    chk_words("t4b_old", 0, 8'h09, 8'h0a, 8'h0b, 8'h0c);
    chk_words("t4b_new", 4, 8'h0d, 8'h0e, 8'h0f, 8'h10);

    // 5: output selection wrap / saturation
    got_q.delete();
    frame(16'h0100, 16'hff00, 16'h0100, 16'hff00);
    drain("t5");
`ifdef CHANNELIZER_SAT_EN
    chk("model_sat", msel(256, 0), 8'h7f);
    chk_words("t5", 0, 8'h7f, 8'h80, 8'h7f, 8'h80);
`else
    chk("model_wrap", msel(256, 0), 8'h00);
    chk_words("t5", 0, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // 6: reset mid-stream and mid-frame
    ordy = 1'b0;
    frame(1, 2, 3, 4);
    smp(1'b1, 7); smp(1'b0, 7);
    arest_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    @(posedge clk); #1 arest_n = 1'b1;
    got_q.delete(); ordy = 1'b1; navg_in = 8'd1; sh_in = 5'd0;
    smp(1'b0, 99);                       // idle sample without fft_ready: dropped
    frame(21, 22, 23, 24);
    drain("t6");
    chk("t6_cnt", got_q.size(), 4);
    chk_words("t6", 0, 8'h15, 8'h16, 8'h17, 8'h18);

    // 7: randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      ordy    = ($urandom_range(0, 3) != 0);
      navg_in = 8'($urandom_range(0, 3));
      sh_in   = 5'($urandom_range(0, 12));
      din     = 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        iv = 1'b0; fr = 1'($urandom_range(0, 1));
      end else begin
        iv = 1'b1;
        fr = m_infr ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 7) != 0);
      end
      @(posedge clk); #1;
    end
    iv = 1'b0; fr = 1'b0;
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
